// File: rtl/threshold_compress_pkg.sv
// rtl/threshold_compress_pkg.sv - shared constants, state encoding and trit helpers for threshold_compress
package threshold_compress_pkg;

    localparam int OUTPUT_WIDTH  = 8;
    localparam int COMPREG_WIDTH = OUTPUT_WIDTH * 5 / 4;
    localparam int COUNTER_MAX   = COMPREG_WIDTH / 2;
    localparam int COUNTER_WIDTH = $clog2(COUNTER_MAX);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_e;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;

    // Anything inside [lo, hi] (inclusive) is the zero trit.
    function automatic logic [1:0] trit_encode(
        input logic [31:0] preact,
        input logic [15:0] thr_lo,
        input logic [15:0] thr_hi
    );
        logic signed [31:0] p;
        logic signed [31:0] lo;
        logic signed [31:0] hi;
        p  = preact;
        lo = {{16{thr_lo[15]}}, thr_lo};
        hi = {{16{thr_hi[15]}}, thr_hi};
        if (p > hi) begin
            return TRIT_POS;
        end else if (p < lo) begin
            return TRIT_NEG;
        end
        return TRIT_ZERO;
    endfunction

    // Base-3 digit used when packing: 0 -> 0, +1 -> 1, -1 -> 2.
    function automatic logic [1:0] trit_digit(input logic [1:0] code);
        case (code)
            TRIT_POS: return 2'd1;
            TRIT_NEG: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/threshold_compress_datapath.sv
// rtl/threshold_compress_datapath.sv - combinational threshold_compress datapath: one trit per call, base-3 packing on fill
module threshold_compress #(
    parameter int OUTPUT_WIDTH = 8
) (
    input  logic [31:0]                                  preactivation_i,
    input  logic [15:0]                                  threshold_lo_i,
    input  logic [15:0]                                  threshold_hi_i,
    input  logic [$clog2(OUTPUT_WIDTH * 5 / 8)-1:0]      counter_i,
    input  logic [OUTPUT_WIDTH * 5 / 4-1:0]              precompressed_i,
    input  logic [OUTPUT_WIDTH-1:0]                      compressed_i,
    output logic [$clog2(OUTPUT_WIDTH * 5 / 8)-1:0]      counter_o,
    output logic [OUTPUT_WIDTH * 5 / 4-1:0]              precompressed_o,
    output logic [OUTPUT_WIDTH-1:0]                      compressed_o,
    output logic                                         compreg_full_o
);
    import threshold_compress_pkg::*;

    localparam int CREG_W  = OUTPUT_WIDTH * 5 / 4;
    localparam int CNT_MAX = CREG_W / 2;
    localparam int CNT_W   = $clog2(CNT_MAX);

    logic [1:0]              trit;
    logic                    full;
    logic [CREG_W-1:0]       next_pre;
    logic [OUTPUT_WIDTH-1:0] packed_word;

    always_comb begin
        trit     = trit_encode(preactivation_i, threshold_lo_i, threshold_hi_i);
        full     = (counter_i == CNT_W'(CNT_MAX - 1));
        next_pre = precompressed_i;
        for (int i = 0; i < CNT_MAX; i++) begin
            if (counter_i == CNT_W'(i)) begin
                next_pre[2*i +: 2] = trit;
            end
        end
        // Trit 0 ends up as the least significant base-3 digit.
        packed_word = '0;
        for (int i = CNT_MAX - 1; i >= 0; i--) begin
            packed_word = packed_word * OUTPUT_WIDTH'(3)
                        + OUTPUT_WIDTH'(trit_digit(next_pre[2*i +: 2]));
        end
        compreg_full_o  = full;
        counter_o       = full ? '0 : counter_i + CNT_W'(1);
        precompressed_o = full ? '0 : next_pre;
        compressed_o    = full ? packed_word : compressed_i;
    end

endmodule

// File: rtl/threshold_compress_ctrl.sv
// rtl/threshold_compress_ctrl.sv - stream sequencer owning threshold_compress state, flush padding and one-entry output buffer
module threshold_compress_ctrl #(
    parameter int OUTPUT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             in_preact_i,
    input  logic [15:0]             in_thr_lo_i,
    input  logic [15:0]             in_thr_hi_i,
    input  logic                    in_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [OUTPUT_WIDTH-1:0] out_data_o,
    output logic [2:0]              out_ntrits_o,
    output logic                    busy_o
);
    import threshold_compress_pkg::*;

    localparam int CREG_W  = OUTPUT_WIDTH * 5 / 4;
    localparam int CNT_MAX = CREG_W / 2;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [0:0] ST_ACCUM = 1'(ACCUM);
    localparam logic [0:0] ST_FLUSH = 1'(FLUSH);

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        counter_q, counter_d;
    logic [CREG_W-1:0]       precomp_q, precomp_d;
    logic [OUTPUT_WIDTH-1:0] comp_q, comp_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [OUTPUT_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [2:0]              buf_ntrits_q, buf_ntrits_d;
    logic [2:0]              ntrits_q, ntrits_d;
    logic [15:0]             pad_lo_q, pad_lo_d;
    logic [15:0]             pad_hi_q, pad_hi_d;
    logic                    run_q, run_d;

    logic [31:0]             dp_preact;
    logic [15:0]             dp_thr_lo;
    logic [15:0]             dp_thr_hi;
    logic [CNT_W-1:0]        dp_counter;
    logic [CREG_W-1:0]       dp_precomp;
    logic [OUTPUT_WIDTH-1:0] dp_comp;
    logic                    dp_full;

    logic in_flush;
    logic stall_full;
    logic ready;
    logic take_in;
    logic take_pad;
    logic advance;
    logic complete;

    // Pad beats feed thr_lo as the preactivation, which always lands on the zero trit.
    assign in_flush  = (state_q == ST_FLUSH);
    assign dp_preact = in_flush ? {{16{pad_lo_q[15]}}, pad_lo_q} : in_preact_i;
    assign dp_thr_lo = in_flush ? pad_lo_q : in_thr_lo_i;
    assign dp_thr_hi = in_flush ? pad_hi_q : in_thr_hi_i;

    threshold_compress #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_datapath (
        .preactivation_i (dp_preact),
        .threshold_lo_i  (dp_thr_lo),
        .threshold_hi_i  (dp_thr_hi),
        .counter_i       (counter_q),
        .precompressed_i (precomp_q),
        .compressed_i    (comp_q),
        .counter_o       (dp_counter),
        .precompressed_o (dp_precomp),
        .compressed_o    (dp_comp),
        .compreg_full_o  (dp_full)
    );

    // Only a completing advance needs buffer space; partial beats keep flowing.
    assign stall_full = buf_valid_q & ~out_ready_i & dp_full;
    assign ready      = run_q & ~in_flush & ~clear_i & ~stall_full;
    assign take_in    = in_valid_i & ready;
    assign take_pad   = in_flush & ~clear_i & ~stall_full;
    assign advance    = take_in | take_pad;
    assign complete   = advance & dp_full;

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        precomp_d    = precomp_q;
        comp_d       = comp_q;
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        buf_ntrits_d = buf_ntrits_q;
        ntrits_d     = ntrits_q;
        pad_lo_d     = pad_lo_q;
        pad_hi_d     = pad_hi_q;
        run_d        = 1'b1;

        if (advance) begin
            counter_d = dp_counter;
            precomp_d = dp_precomp;
            comp_d    = dp_comp;
        end

        if (take_in) begin
            ntrits_d = complete ? 3'd0 : ntrits_q + 3'd1;
        end else if (complete) begin
            ntrits_d = 3'd0;
        end

        if (buf_valid_q && out_ready_i) begin
            buf_valid_d = 1'b0;
        end
        if (complete) begin
            buf_valid_d  = 1'b1;
            buf_data_d   = dp_comp;
            buf_ntrits_d = take_in ? ntrits_q + 3'd1 : ntrits_q;
        end

        if (take_in && in_last_i && !dp_full) begin
            state_d  = ST_FLUSH;
            pad_lo_d = in_thr_lo_i;
            pad_hi_d = in_thr_hi_i;
        end else if (take_pad && complete) begin
            state_d = ST_ACCUM;
        end

        if (clear_i) begin
            state_d      = ST_ACCUM;
            counter_d    = '0;
            precomp_d    = '0;
            comp_d       = '0;
            buf_valid_d  = 1'b0;
            buf_data_d   = '0;
            buf_ntrits_d = 3'd0;
            ntrits_d     = 3'd0;
            pad_lo_d     = 16'd0;
            pad_hi_d     = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACCUM;
            counter_q    <= '0;
            precomp_q    <= '0;
            comp_q       <= '0;
            buf_valid_q  <= 1'b0;
            buf_data_q   <= '0;
            buf_ntrits_q <= 3'd0;
            ntrits_q     <= 3'd0;
            pad_lo_q     <= 16'd0;
            pad_hi_q     <= 16'd0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            precomp_q    <= precomp_d;
            comp_q       <= comp_d;
            buf_valid_q  <= buf_valid_d;
            buf_data_q   <= buf_data_d;
            buf_ntrits_q <= buf_ntrits_d;
            ntrits_q     <= ntrits_d;
            pad_lo_q     <= pad_lo_d;
            pad_hi_q     <= pad_hi_d;
            run_q        <= run_d;
        end
    end

    assign in_ready_o   = ready;
    assign out_valid_o  = buf_valid_q;
    assign out_data_o   = buf_data_q;
    assign out_ntrits_o = buf_ntrits_q;
    assign busy_o       = in_flush | (counter_q != '0);

endmodule

// File: tb/tb_threshold_compress_ctrl.sv
// tb/tb_threshold_compress_ctrl.sv - directed self-checking bench for threshold_compress_ctrl
module tb_threshold_compress_ctrl;

    logic        clk;
    logic        rst_n;
    logic        clear_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_preact_i;
    logic [15:0] in_thr_lo_i;
    logic [15:0] in_thr_hi_i;
    logic        in_last_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic [2:0]  out_ntrits_o;
    logic        busy_o;

    int checks;
    int failures;
    int stalls;

    logic [7:0] word_q[$];
    logic [2:0] ntr_q[$];

    threshold_compress_ctrl #(
        .OUTPUT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_preact_i  (in_preact_i),
        .in_thr_lo_i  (in_thr_lo_i),
        .in_thr_hi_i  (in_thr_hi_i),
        .in_last_i    (in_last_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_ntrits_o (out_ntrits_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid_o && out_ready_i) begin
            word_q.push_back(out_data_o);
            ntr_q.push_back(out_ntrits_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat and returns 1 time unit after the edge that accepted it.
    task automatic send(input int p, input int last);
        int n;
        in_valid_i  = 1'b1;
        in_preact_i = p;
        in_thr_lo_i = -16'sd10;
        in_thr_hi_i = 16'sd10;
        in_last_i   = (last != 0);
        n = 0;
        @(negedge clk);
        if (!in_ready_o) stalls++;
        while (!in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic send_grp1();
        send(100, 0);
        send(-100, 0);
        send(0, 0);
        send(100, 0);
        send(-100, 0);
    endtask

    initial begin
        int pat[3];
        checks      = 0;
        failures    = 0;
        stalls      = 0;
        rst_n       = 1'b0;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_preact_i = 32'd0;
        in_thr_lo_i = 16'd0;
        in_thr_hi_i = 16'd0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;
        pat[0] = 100;
        pat[1] = 0;
        pat[2] = -100;

        // Reset state
        #7;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_data", 32'(out_data_o), 32'd0);
        chk("rst_ntrits", 32'(out_ntrits_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One full group {+,-,0,+,-} -> 1 + 2*3 + 1*27 + 2*81 = 196
        send(100, 0);
        send(-100, 0);
        send(0, 0);
        send(100, 0);
        chk("g1_no_early_valid", 32'(out_valid_o), 32'd0);
        chk("g1_busy_mid", 32'(busy_o), 32'd1);
        send(-100, 0);
        chk("g1_valid", 32'(out_valid_o), 32'd1);
        chk("g1_data", 32'(out_data_o), 32'd196);
        chk("g1_ntrits", 32'(out_ntrits_o), 32'd5);
        chk("g1_busy_after", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        chk("g1_drained", 32'(out_valid_o), 32'd0);

        // 20 back-to-back beats, trits cycle +,0,- -> words 46, 140, 177, 46
        word_q.delete();
        ntr_q.delete();
        stalls = 0;
        for (int i = 0; i < 20; i++) send(pat[i % 3], 0);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_stalls", 32'(stalls), 32'd0);
        chk("b2b_count", 32'(word_q.size()), 32'd4);
        chk("b2b_w0", 32'(word_q[0]), 32'd46);
        chk("b2b_w1", 32'(word_q[1]), 32'd140);
        chk("b2b_w2", 32'(word_q[2]), 32'd177);
        chk("b2b_w3", 32'(word_q[3]), 32'd46);
        chk("b2b_n3", 32'(ntr_q[3]), 32'd5);

        // Flush after 2 real trits {+,-,0,0,0} -> 7
        send(100, 0);
        send(-100, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fl_in_ready", 32'(in_ready_o), 32'd0);
            chk("fl_busy", 32'(busy_o), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("fl_valid", 32'(out_valid_o), 32'd1);
        chk("fl_data", 32'(out_data_o), 32'd7);
        chk("fl_ntrits", 32'(out_ntrits_o), 32'd2);
        chk("fl_busy_fall", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: word 1 = 196 held, word 2 = all negative -> 242
        out_ready_i = 1'b0;
        send_grp1();
        chk("bp_w1_valid", 32'(out_valid_o), 32'd1);
        stalls = 0;
        for (int i = 0; i < 4; i++) send(-100, 0);
        chk("bp_partial_stalls", 32'(stalls), 32'd0);
        in_valid_i  = 1'b1;
        in_preact_i = -100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready_o), 32'd0);
            chk("bp_w1_stable", 32'(out_data_o), 32'd196);
            chk("bp_w1_held", 32'(out_valid_o), 32'd1);
        end
        out_ready_i = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        chk("bp_w2_valid", 32'(out_valid_o), 32'd1);
        chk("bp_w2_data", 32'(out_data_o), 32'd242);
        @(posedge clk);
        #1;
        chk("bp_w2_drained", 32'(out_valid_o), 32'd0);

        // clear_i drops a buffered word and a partial group
        out_ready_i = 1'b0;
        send_grp1();
        send(-100, 0);
        send(-100, 0);
        send(-100, 0);
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        chk("clr_valid", 32'(out_valid_o), 32'd0);
        chk("clr_busy", 32'(busy_o), 32'd0);
        out_ready_i = 1'b1;
        send_grp1();
        chk("clr_g_valid", 32'(out_valid_o), 32'd1);
        chk("clr_g_data", 32'(out_data_o), 32'd196);
        chk("clr_g_ntrits", 32'(out_ntrits_o), 32'd5);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-FLUSH
        send(100, 1);
        chk("ar_flush_busy", 32'(busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid_o), 32'd0);
        chk("ar_data", 32'(out_data_o), 32'd0);
        chk("ar_ntrits", 32'(out_ntrits_o), 32'd0);
        chk("ar_busy", 32'(busy_o), 32'd0);
        chk("ar_in_ready", 32'(in_ready_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_grp1();
        chk("ar_g_data", 32'(out_data_o), 32'd196);
        chk("ar_g_ntrits", 32'(out_ntrits_o), 32'd5);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/threshold_compress_ctrl.md
Name: threshold_compress_ctrl

Overview:
Stream sequencer wrapped around the combinational threshold_compress datapath. It owns the counter, precompressed and compressed state registers that the datapath reads and updates. It accepts one preactivation plus threshold pair per beat and advances the datapath once per accepted beat. It emits one packed OUTPUT_WIDTH word per COUNTER_MAX trits, supports early flush with zero-trit padding, and applies backpressure through a one-entry output buffer.

Parameters:
OUTPUT_WIDTH, 8, packed output word width; must be a multiple of 4.
COMPREG_WIDTH, OUTPUT_WIDTH*5/4, precompressed register width (2 bits per trit).
COUNTER_MAX, COMPREG_WIDTH/2, trits per output word (5 at default).
COUNTER_WIDTH, $clog2(COUNTER_MAX), datapath counter width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
clear_i  in  1  synchronous abort; drops partial group and output buffer
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when valid&ready
in_preact_i  in  32  preactivation
in_thr_lo_i  in  16  low threshold
in_thr_hi_i  in  16  high threshold
in_last_i  in  1  last beat of stream; flush partial group after it
out_valid_o  out  1  packed word valid
out_ready_i  in  1  consumer ready
out_data_o  out  OUTPUT_WIDTH  packed word (datapath compressed_o)
out_ntrits_o  out  3  real trits in word, 1..COUNTER_MAX; fewer than COUNTER_MAX only after flush
busy_o  out  1  partial group pending or FLUSH active

Behaviour:
- Reset: state ACCUM; counter_q, precompressed_q, compressed_q = 0; out_valid_o=0, out_data_o=0, out_ntrits_o=0, busy_o=0, in_ready_o=0 during reset.
- Datapath inputs: counter_i/precompressed_i/compressed_i come from the owned registers. Threshold/preact inputs are muxed from the input port (ACCUM) or the pad source (FLUSH).
- Update rule: the state registers load the datapath _o values only on an advance (accepted input beat or pad beat). Otherwise they hold.
- Group completion = advance while datapath compreg_full_o=1. In that cycle compressed_o loads the output buffer (out_valid_o=1 next cycle, latency 1 from the completing beat). out_ntrits_o gets the real-trit count. Counter wraps to 0 through the datapath.
- Output buffer: one entry, cleared on out_valid_o&out_ready_i. A completing advance is allowed only if the buffer is empty or is being drained in the same cycle (back-to-back groups at full rate).
- in_ready_o = (state==ACCUM) & ~clear_i & ~(buffer_full & ~out_ready_i & counter_q==COUNTER_MAX-1). Non-completing beats are accepted even while the buffer is stalled.
- States:
  - ACCUM: accept beats.
    - in_last_i accepted on a completing beat: stay ACCUM.
    - in_last_i accepted on a non-completing beat: go to FLUSH, latch real-trit count = counter_q+1, latch pad thresholds = that beat's thr_lo/thr_hi.
  - FLUSH: in_ready_o=0. One pad beat per cycle with preactivation = latched thr_lo, which encodes the zero trit (lo <= p <= hi). Pad beats obey the same completion/stall rule. Return to ACCUM on the completing pad beat.
- Real-trit counter: 3 bits, increments on real beats, resets to 0 on completion.
- clear_i has priority over everything. Next cycle: state ACCUM, all state registers 0, output buffer invalid (valid word dropped). Applies mid-FLUSH too.
- Async reset mid-group: same effect as clear_i, immediate.
- in_valid_i may drop between beats; there is no timeout and the partial group is held indefinitely.
- The controller must not drop out_valid_o or change out_data_o while out_ready_i=0 (AXI-stream stable rule).

Decomposition:
- Package threshold_compress_pkg: OUTPUT_WIDTH-derived constants (COMPREG_WIDTH, COUNTER_MAX, COUNTER_WIDTH), ctrl_state_e {ACCUM, FLUSH}, trit code localparams.
- Sub-module: one instance of threshold_compress; all state and sequencing stay in this block.

Test Plan:
- Reset, then 5 beats thr_lo=-10, thr_hi=10, preact {100,-100,0,100,-100}, out_ready=1 -> exactly one out_valid one cycle after beat 5, out_ntrits=5, out_data equals golden threshold_compress value.
- 20 consecutive beats, out_ready=1 -> 4 words, no in_ready deassertion, each word equals golden value.
- 2 beats (preact 100, -100) with in_last on beat 2 -> 3 pad cycles with in_ready=0, then word with out_ntrits=2 equal to golden({+,-,0,0,0}); busy_o falls after.
- out_ready=0 with 10 beats offered -> first word held stable; beats 6-9 accepted; in_ready=0 on beat 10 until out_ready=1, then word 2 emitted; no loss.
- clear_i after 3 beats -> next 5 beats produce a word identical to a fresh 5-beat group; buffered word dropped.
- Async rst_n mid-FLUSH -> all outputs at reset values; subsequent group correct.
